// File: rtl/visited_store_mp_pkg.sv
// Shared constants and types for the multi-port visited/predecessor store.
// The macros are kept here so every later file in the compilation sees them.
`ifndef VISITED_STORE_MP_CONSTANTS
`define VISITED_STORE_MP_CONSTANTS
`define UNVISITED               8'hFF
`define DEFAULT_MAX_NODES       16
`define DEFAULT_INDEX_WIDTH     8
`define DEFAULT_NUM_PORTS       2
`define DEFAULT_CLEAR_PER_CYCLE 4
`endif

package visited_store_mp_pkg;
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;
endpackage

// File: rtl/visited_store_mp_if.sv
// Visit-write bundle: per-port requests in, registered ack/error pulses out.
interface visited_store_mp_if #(
  parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
  parameter int NUM_PORTS   = `DEFAULT_NUM_PORTS
);
  logic [NUM_PORTS-1:0]             set_en;
  logic [INDEX_WIDTH*NUM_PORTS-1:0] index;
  logic [INDEX_WIDTH*NUM_PORTS-1:0] prev_node;
  logic [NUM_PORTS-1:0]             set_ack;
  logic                             dup_err;
  logic                             oor_err;

  modport master (output set_en, index, prev_node, input set_ack, dup_err, oor_err);
  modport slave  (input set_en, index, prev_node, output set_ack, dup_err, oor_err);
endinterface

// File: rtl/visited_store_mp_lowest_unset_finder.sv
// Priority encoder returning the lowest zero bit of a vector.
module lowest_unset_finder #(
  parameter int WIDTH       = 16,
  parameter int INDEX_WIDTH = 8
) (
  input  logic [WIDTH-1:0]       bits,
  output logic [INDEX_WIDTH-1:0] index,
  output logic                   valid
);
  always_comb begin
    index = '0;
    valid = 1'b0;
    for (int j = WIDTH - 1; j >= 0; j--) begin
      if (!bits[j]) begin
        index = INDEX_WIDTH'(j);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/visited_store_mp.sv
// Visited flags and predecessor table with NUM_PORTS visit writes per cycle,
// multi-cycle soft clear, registered query port and lowest-unvisited finder.
module visited_store_mp
  import visited_store_mp_pkg::*;
#(
  parameter int MAX_NODES       = `DEFAULT_MAX_NODES,
  parameter int INDEX_WIDTH     = `DEFAULT_INDEX_WIDTH,
  parameter int NUM_PORTS       = `DEFAULT_NUM_PORTS,
  parameter int CLEAR_PER_CYCLE = `DEFAULT_CLEAR_PER_CYCLE
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [INDEX_WIDTH-1:0]           number_of_nodes,
  input  logic                             clear_start,
  visited_store_mp_if.slave                wr,
  output logic                             busy,
  output logic [INDEX_WIDTH-1:0]           unvisited_nodes,
  output logic [INDEX_WIDTH-1:0]           next_unvisited,
  output logic                             next_unvisited_valid,
  input  logic [INDEX_WIDTH-1:0]           query_index,
  output logic                             query_visited,
  output logic [INDEX_WIDTH-1:0]           query_prev,
  output logic [INDEX_WIDTH*MAX_NODES-1:0] prev_vector_flattened
);
  localparam int AW = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
  localparam logic [INDEX_WIDTH:0]   MAX_IDX = (INDEX_WIDTH + 1)'(MAX_NODES);
  localparam logic [AW-1:0]          LAST_PTR = AW'(MAX_NODES - CLEAR_PER_CYCLE);
  localparam logic [INDEX_WIDTH-1:0] UNV = INDEX_WIDTH'(`UNVISITED);

  clr_state_e                 state_q, state_d;
  logic [AW-1:0]              ptr_q, ptr_d;
  logic [MAX_NODES-1:0]       visited_q, visited_d;
  logic [INDEX_WIDTH-1:0]     prev_q [MAX_NODES];
  logic [INDEX_WIDTH-1:0]     prev_d [MAX_NODES];
  logic [INDEX_WIDTH-1:0]     count_q, count_d;
  logic [NUM_PORTS-1:0]       ack_q, ack_d;
  logic                       dup_q, dup_d, oor_q, oor_d;
  logic                       qv_q, qv_d;
  logic [INDEX_WIDTH-1:0]     qp_q, qp_d;

  logic                       idle;
  logic [INDEX_WIDTH-1:0]     idx   [NUM_PORTS];
  logic [AW-1:0]              idx_lo[NUM_PORTS];
  logic [INDEX_WIDTH-1:0]     pnode [NUM_PORTS];
  logic [NUM_PORTS-1:0]       in_range, cand, accept;
  logic [MAX_NODES-1:0]       in_mask;
  logic [INDEX_WIDTH-1:0]     find_idx;
  logic                       find_valid;
  logic                       q_in;

  assign idle = (state_q == ST_IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign idx[gi]      = wr.index[INDEX_WIDTH*gi +: INDEX_WIDTH];
      assign pnode[gi]    = wr.prev_node[INDEX_WIDTH*gi +: INDEX_WIDTH];
      assign idx_lo[gi]   = idx[gi][AW-1:0];
      assign in_range[gi] = (idx[gi] < number_of_nodes) && ({1'b0, idx[gi]} < MAX_IDX);
      assign cand[gi]     = wr.set_en[gi] && idle && in_range[gi];
    end
    for (gi = 0; gi < MAX_NODES; gi++) begin : g_node
      assign in_mask[gi] = {1'b0, number_of_nodes} > (INDEX_WIDTH + 1)'(gi);
      assign prev_vector_flattened[INDEX_WIDTH*gi +: INDEX_WIDTH] = prev_q[gi];
    end
  endgenerate

  // Any in-range request on a lower port to the same index blocks this port,
  // whether or not that lower request is itself accepted.
  always_comb begin
    accept = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      accept[p] = cand[p] && !visited_q[idx_lo[p]];
      for (int q = 0; q < p; q++) begin
        if (cand[q] && (idx[q] == idx[p])) accept[p] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    visited_d = visited_q;
    prev_d    = prev_q;
    count_d   = count_q;
    ack_d     = accept;
    dup_d     = |(cand & ~accept);
    oor_d     = idle && |(wr.set_en & ~in_range);
    case (state_q)
      ST_IDLE: begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (accept[p]) begin
            visited_d[idx_lo[p]] = 1'b1;
            prev_d[idx_lo[p]]    = pnode[p];
            count_d              = count_d + 1'b1;
          end
        end
        if (clear_start) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        for (int k = 0; k < CLEAR_PER_CYCLE; k++) begin
          visited_d[ptr_q + AW'(k)] = 1'b0;
          prev_d[ptr_q + AW'(k)]    = UNV;
        end
        ptr_d = ptr_q + AW'(CLEAR_PER_CYCLE);
        if (ptr_q == LAST_PTR) begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      end
    endcase
  end

  // Query reads the pre-edge table, so same-edge writes are not visible yet.
  always_comb begin
    q_in = {1'b0, query_index} < MAX_IDX;
    qv_d = q_in ? visited_q[query_index[AW-1:0]] : 1'b0;
    qp_d = q_in ? prev_q[query_index[AW-1:0]] : UNV;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      visited_q <= '0;
      for (int j = 0; j < MAX_NODES; j++) prev_q[j] <= UNV;
      count_q   <= '0;
      ack_q     <= '0;
      dup_q     <= 1'b0;
      oor_q     <= 1'b0;
      qv_q      <= 1'b0;
      qp_q      <= UNV;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      visited_q <= visited_d;
      prev_q    <= prev_d;
      count_q   <= count_d;
      ack_q     <= ack_d;
      dup_q     <= dup_d;
      oor_q     <= oor_d;
      qv_q      <= qv_d;
      qp_q      <= qp_d;
    end
  end

  lowest_unset_finder #(
    .WIDTH       (MAX_NODES),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_finder (
    .bits  (visited_q | ~in_mask),
    .index (find_idx),
    .valid (find_valid)
  );

  assign busy                 = (state_q == ST_CLEAR);
  assign unvisited_nodes      = number_of_nodes - count_q;
  assign next_unvisited_valid = find_valid && !busy;
  assign next_unvisited       = next_unvisited_valid ? find_idx : '0;
  assign query_visited        = qv_q;
  assign query_prev           = qp_q;
  assign wr.set_ack           = ack_q;
  assign wr.dup_err           = dup_q;
  assign wr.oor_err           = oor_q;
endmodule
